// File: rtl/alu_sequencer.sv
// Multi-pass sequencer for the 8-bit Game Boy ALU: OP8, ADD16, ADD SP,e8 and NOP requests.
// Optional ALU_SEQ_OVERLAP_EN lets a new request be accepted in the response handshake cycle.

package gate_boy_pkg;
  parameter int unsigned DATA_WIDTH = 8;
  parameter int unsigned FLAG_WIDTH = 8;
  typedef enum logic [2:0] {
    AluAdd, AluAdc, AluSub, AluSbc, AluAnd, AluXor, AluOr, AluCp
  } alu_ops_t;
endpackage

module alu_sequencer
  import gate_boy_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_cmd,
  input  alu_ops_t              req_alu_op,
  input  logic [15:0]           req_a,
  input  logic [15:0]           req_b,
  input  logic [FLAG_WIDTH-1:0] req_flags_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_result,
  output logic [FLAG_WIDTH-1:0] rsp_flags,
  output logic [DATA_WIDTH-1:0] alu_operand_A,
  output logic [DATA_WIDTH-1:0] alu_operand_B,
  output alu_ops_t              alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [FLAG_WIDTH-1:0] alu_flags
);

  typedef enum logic [1:0] {CmdOp8, CmdAdd16, CmdAddSp, CmdNop} cmd_e;
  typedef enum logic [2:0] {StIdle, StPrime, StPassLo, StPassHi, StCapt, StDone} state_e;

  state_e          state_q, state_d;
  cmd_e            cmd_q;
  alu_ops_t        op_q;
  logic [15:0]     a_q, b_q;
  logic            z_in_q, c_in_q;
  logic [7:0]      lo_q;
  logic [1:0]      hc_q;
  logic [15:0]     rsp_result_q;
  logic [7:0]      rsp_flags_q;
  logic            accept;

  function automatic state_e first_state(input cmd_e cmd, input alu_ops_t op);
    if (cmd == CmdNop) return StDone;
    if (cmd == CmdOp8 && (op == AluAdc || op == AluSbc)) return StPrime;
    return StPassLo;
  endfunction

  always_comb begin
    req_ready = 1'b0;
    if (!rst) begin
      if (state_q == StIdle) req_ready = 1'b1;
`ifdef ALU_SEQ_OVERLAP_EN
      else if (state_q == StDone) req_ready = rsp_ready;
`endif
    end
  end

  assign accept     = req_valid && req_ready;
  assign rsp_valid  = (state_q == StDone);
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = first_state(cmd_e'(req_cmd), req_alu_op);
      StPrime:  state_d = StPassLo;
      StPassLo: state_d = (cmd_q == CmdOp8) ? StCapt : StPassHi;
      StPassHi: state_d = StCapt;
      StCapt:   state_d = StDone;
      StDone: begin
        if (rsp_ready) state_d = accept ? first_state(cmd_e'(req_cmd), req_alu_op) : StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  // ALU sees ADD 0,0 whenever no pass is in flight.
  always_comb begin
    alu_opcode    = AluAdd;
    alu_operand_A = '0;
    alu_operand_B = '0;
    unique case (state_q)
      StPrime: begin
        // 0xFF + carry sets the ALU carry register to the CPU carry.
        alu_operand_A = 8'hFF;
        alu_operand_B = {7'b0, c_in_q};
      end
      StPassLo: begin
        alu_opcode    = (cmd_q == CmdOp8) ? op_q : AluAdd;
        alu_operand_A = a_q[7:0];
        alu_operand_B = b_q[7:0];
      end
      StPassHi: begin
        alu_opcode    = AluAdc;
        alu_operand_A = a_q[15:8];
        alu_operand_B = (cmd_q == CmdAddSp) ? {8{b_q[7]}} : b_q[15:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cmd_q        <= CmdNop;
      op_q         <= AluAdd;
      a_q          <= '0;
      b_q          <= '0;
      z_in_q       <= 1'b0;
      c_in_q       <= 1'b0;
      lo_q         <= '0;
      hc_q         <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q  <= cmd_e'(req_cmd);
        op_q   <= req_alu_op;
        a_q    <= req_a;
        b_q    <= req_b;
        z_in_q <= req_flags_in[7];
        c_in_q <= req_flags_in[4];
        if (cmd_e'(req_cmd) == CmdNop) begin
          rsp_result_q <= req_a;
          rsp_flags_q  <= req_flags_in & 8'hF0;
        end
      end
      // alu_result here is the registered output of the low pass.
      if (state_q == StPassHi) begin
        lo_q <= alu_result;
        hc_q <= alu_flags[5:4];
      end
      if (state_q == StCapt) begin
        case (cmd_q)
          CmdOp8: begin
            rsp_result_q <= {8'h00, alu_result};
            rsp_flags_q  <= alu_flags;
          end
          CmdAdd16: begin
            rsp_result_q <= {alu_result, lo_q};
            rsp_flags_q  <= {z_in_q, 1'b0, alu_flags[5:4], 4'b0};
          end
          CmdAddSp: begin
            rsp_result_q <= {alu_result, lo_q};
            rsp_flags_q  <= {2'b00, hc_q, 4'b0};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: registered Game Boy ALU model plus a 16-bit reference model.
module tb_alu_sequencer;
  import gate_boy_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_cmd = 2'd3;
  alu_ops_t    req_alu_op = AluAdd;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [7:0]  req_flags_in = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [7:0]  rsp_flags;
  logic [7:0]  alu_operand_A, alu_operand_B;
  alu_ops_t    alu_opcode;
  logic [7:0]  alu_result = '0;
  logic [7:0]  alu_flags = '0;

  int total = 0;
  int bad = 0;
  alu_ops_t   t1_op;
  logic [7:0] t1_a, t1_b;

`ifdef ALU_SEQ_OVERLAP_EN
  localparam int Gap = 4;
`else
  localparam int Gap = 5;
`endif

  alu_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_alu_op(req_alu_op), .req_a(req_a), .req_b(req_b), .req_flags_in(req_flags_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags),
    .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  // Byte ALU per Game Boy flag rules; returns {flags, result}.
  function automatic logic [15:0] gb_alu(input alu_ops_t op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
    int s, hs, ci;
    logic [7:0] r;
    logic z, n, h, c;
    ci = (op == AluAdc || op == AluSbc) ? int'(cin) : 0;
    n = 0; h = 0; c = 0; r = '0; s = 0; hs = 0;
    case (op)
      AluAdd, AluAdc: begin
        s = int'(a) + int'(b) + ci;
        hs = int'(a[3:0]) + int'(b[3:0]) + ci;
        r = s[7:0]; h = hs > 15; c = s > 255;
      end
      AluSub, AluSbc, AluCp: begin
        s = int'(a) - int'(b) - ci;
        hs = int'(a[3:0]) - int'(b[3:0]) - ci;
        r = (op == AluCp) ? a : s[7:0]; n = 1; h = hs < 0; c = s < 0;
      end
      AluAnd: begin r = a & b; h = 1; end
      AluXor: r = a ^ b;
      default: r = a | b;
    endcase
    z = (op == AluCp) ? (a == b) : (r == 8'h00);
    return {z, n, h, c, 4'b0000, r};
  endfunction

  always @(posedge clk)
    {alu_flags, alu_result} <= gb_alu(alu_opcode, alu_operand_A, alu_operand_B, alu_flags[4]);

  task automatic ref_model(input logic [1:0] cmd, input alu_ops_t op, input logic [15:0] a,
                           input logic [15:0] b, input logic [7:0] f,
                           output logic [15:0] r, output logic [7:0] fl, output int lat);
    logic [16:0] s;
    logic [15:0] e;
    logic [15:0] t;
    logic h, c;
    case (cmd)
      2'd0: begin
        t = gb_alu(op, a[7:0], b[7:0], f[4]);
        r = {8'h00, t[7:0]}; fl = t[15:8];
        lat = (op == AluAdc || op == AluSbc) ? 4 : 3;
      end
      2'd1: begin
        s = {1'b0, a} + {1'b0, b};
        h = ({1'b0, a[11:0]} + {1'b0, b[11:0]}) > 13'hFFF;
        r = s[15:0]; fl = {f[7], 1'b0, h, s[16], 4'b0}; lat = 4;
      end
      2'd2: begin
        e = {{8{b[7]}}, b[7:0]};
        r = a + e;
        h = (a[3:0] + b[3:0]) > 5'd15;
        c = ({1'b0, a[7:0]} + {1'b0, b[7:0]}) > 9'd255;
        fl = {2'b00, h, c, 4'b0}; lat = 4;
      end
      default: begin r = a; fl = f & 8'hF0; lat = 1; end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic [1:0] cmd, input alu_ops_t op,
                        input logic [15:0] a, input logic [15:0] b, input logic [7:0] f,
                        input int hold);
    logic [15:0] er;
    logic [7:0] ef;
    int el, n;
    ref_model(cmd, op, a, b, f, er, ef, el);
    @(negedge clk);
    check({tag, ":ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_cmd = cmd; req_alu_op = op; req_a = a; req_b = b;
    req_flags_in = f;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    t1_op = alu_opcode; t1_a = alu_operand_A; t1_b = alu_operand_B;
    while (!rsp_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":latency"}, 32'(n), 32'(el));
    check({tag, ":result"}, 32'(rsp_result), 32'(er));
    check({tag, ":flags"}, 32'(rsp_flags), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ":held"}, {7'b0, rsp_valid, rsp_result, rsp_flags},
            {7'b0, 1'b1, er, ef});
      check({tag, ":busy"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ":released"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int n_acc, n_rsp;
    int rsp_t[2];
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_flags", 32'(rsp_flags), 32'd0);
    check("rst_alu", {16'(alu_opcode), alu_operand_A, alu_operand_B}, {16'(AluAdd), 16'h0});
    rst = 1'b0;

    // Directed vectors
    do_req("op8_add", 2'd0, AluAdd, 16'h003A, 16'h00C6, 8'h00, 0);
    do_req("add16", 2'd1, AluAdd, 16'h8A23, 16'h0605, 8'h80, 0);
    check("add16_vec", {rsp_result, 8'h0, rsp_flags}, {16'h9028, 16'h00A0});
    do_req("addsp_neg", 2'd2, AluAdd, 16'h0005, 16'h00FE, 8'h00, 0);
    check("addsp_neg_vec", {rsp_result, 8'h0, rsp_flags}, {16'h0003, 16'h0030});
    do_req("addsp_wrap", 2'd2, AluAdd, 16'hFFF8, 16'h0008, 8'h80, 0);
    check("addsp_wrap_vec", {rsp_result, 8'h0, rsp_flags}, {16'h0000, 16'h0030});
    do_req("op8_adc", 2'd0, AluAdc, 16'h000F, 16'h0000, 8'h10, 0);
    check("adc_prime", {16'(t1_op), t1_a, t1_b}, {16'(AluAdd), 8'hFF, 8'h01});
    check("adc_vec", {rsp_result, 8'h0, rsp_flags}, {16'h0010, 16'h0020});
    do_req("sbc_nocarry", 2'd0, AluSbc, 16'h0010, 16'h0001, 8'h00, 0);
    do_req("nop", 2'd3, AluAdd, 16'hBEEF, 16'h1234, 8'hFF, 1);
    do_req("backpressure", 2'd1, AluAdd, 16'h8A23, 16'h0605, 8'h80, 5);

    // Reset during PASS_HI of an ADD16
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 2'd1; req_a = 16'h1234; req_b = 16'h4321;
    req_flags_in = 8'h00;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pass_hi_op", 32'(alu_opcode), 32'(AluAdc));
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(req_ready), 32'd0);
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp", {rsp_result, 8'h0, rsp_flags}, 32'h0);
    check("midrst_alu", {16'(alu_opcode), alu_operand_A, alu_operand_B}, {16'(AluAdd), 16'h0});
    @(negedge clk);
    check("midrst_hold", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    do_req("xor_after_rst", 2'd0, AluXor, 16'h00FF, 16'h00FF, 8'h30, 0);
    check("xor_vec", {rsp_result, 8'h0, rsp_flags}, {16'h0000, 16'h0080});

    // Two queued ADD16 requests with rsp_ready held high
    @(negedge clk);
    n_acc = 0; n_rsp = 0; rsp_t[0] = 0; rsp_t[1] = 0;
    req_valid = 1'b1; req_cmd = 2'd1; req_a = 16'h8A23; req_b = 16'h0605;
    req_flags_in = 8'h80; rsp_ready = 1'b1;
    for (int i = 0; i < 30 && n_rsp < 2; i++) begin
      if (i > 0) @(negedge clk);
      if (rsp_valid) begin
        check("ovl_rsp", {rsp_result, 8'h0, rsp_flags}, {16'h9028, 16'h00A0});
        rsp_t[n_rsp] = i;
        n_rsp++;
      end
      if (n_acc == 2) req_valid = 1'b0;
      if (req_valid && req_ready) n_acc++;
    end
    check("ovl_count", 32'(n_rsp), 32'd2);
    check("ovl_gap", 32'(rsp_t[1] - rsp_t[0]), 32'(Gap));
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Random requests against the reference model
    for (int k = 0; k < 40; k++) begin
      do_req("rand", 2'($urandom_range(0, 3)), alu_ops_t'($urandom_range(0, 7)),
             16'($urandom), 16'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
